data_mem_responder: RTL

Multi-cycle data-memory responder: the memory-side end of the core's load/store interface. It accepts one word request at a time through a valid/ready handshake and inserts a configurable number of wait states. It performs byte-masked writes or word reads on internal storage, then holds the response until the requester takes it. It also decodes a small MMIO window: a `tohost` output register and a free-running cycle counter. This lets the core be moved off combinational memory onto a realistic stalling memory port.

---
 rtl/mem_if_pkg.sv | 42 ++++
 rtl/mem_wait_counter.sv | 27 ++
 rtl/data_mem_responder.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared types and constants for the data memory responder
package mem_if_pkg;

  // Request lifecycle: accept in IDLE, count wait states in WAIT, hold response in RESP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Target selected by the address decoder
  typedef enum logic [1:0] {
    RG_MEM    = 2'd0,
    RG_TOHOST = 2'd1,
    RG_CYCLE  = 2'd2,
    RG_FAULT  = 2'd3
  } region_t;

  // Why an access faulted; collapsed to the single resp_err bit at the port
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_UNMAPPED = 2'd2
  } resp_err_t;

  // Register offsets inside the MMIO window
  localparam logic [31:0] MMIO_TOHOST_OFS = 32'd0;
  localparam logic [31:0] MMIO_CYCLE_OFS  = 32'd4;

  // Byte-lane merge: lanes with a set strobe take the new data, others keep the old value
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) result[8*b +: 8] = wdata[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - loadable down-counter flagging when the wait has elapsed
module mem_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load wins over counting; the counter parks at zero once expired
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - stalling word memory with tohost and cycle-counter MMIO
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] tohost,
  output logic        tohost_valid
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
  // The counter starts at WAIT_STATES-1 so that WAIT lasts exactly WAIT_STATES cycles
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic        h_write;
  logic [31:0] h_addr;
  logic [31:0] h_wdata;
  logic [3:0]  h_wstrb;

  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic [IDX_W-1:0] acc_idx;
  region_t     region;
  resp_err_t   err_code;

  logic        accept;
  logic        exec;
  logic        wait_done;
  logic [31:0] cycle_cnt;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state == ST_IDLE) && req_valid;

  // With no wait states the access runs on the accept edge itself, straight from the request
  assign exec = (WAIT_STATES == 0) ? accept : ((state == ST_WAIT) && wait_done);

  mem_wait_counter #(
    .WIDTH (4)
  ) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (accept && (WAIT_STATES > 0)),
    .load_value (WAIT_LOAD),
    .done       (wait_done)
  );

  // Operand source: live request bus while idle, holding registers afterwards
  always_comb begin
    acc_write = h_write;
    acc_addr  = h_addr;
    acc_wdata = h_wdata;
    acc_wstrb = h_wstrb;
    if (state == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end
  end

  assign acc_idx = acc_addr[IDX_W+1:2];

  // Address decode; alignment is checked before any region so misaligned MMIO also faults
  always_comb begin
    region   = RG_FAULT;
    err_code = ERR_UNMAPPED;
    if (acc_addr[1:0] != 2'b00) begin
      err_code = ERR_MISALIGN;
    end else if (acc_addr < MEM_BYTES) begin
      region   = RG_MEM;
      err_code = ERR_NONE;
    end else if (acc_addr == (MMIO_BASE + MMIO_TOHOST_OFS)) begin
      region   = RG_TOHOST;
      err_code = ERR_NONE;
    end else if (acc_addr == (MMIO_BASE + MMIO_CYCLE_OFS)) begin
      region   = RG_CYCLE;
      err_code = ERR_NONE;
    end
  end

  // Free-running cycle counter, visible through the MMIO window
  always_ff @(posedge clk) begin
    if (reset) cycle_cnt <= '0;
    else       cycle_cnt <= cycle_cnt + 32'd1;
  end

  // Storage write port; contents survive reset, and reset blocks a store that is still pending
  always_ff @(posedge clk) begin
    if (!reset && exec && acc_write && (region == RG_MEM)) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Request FSM with registered handshake, response and tohost outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      tohost       <= '0;
      tohost_valid <= 1'b0;
    end else begin
      tohost_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            h_write   <= req_write;
            h_addr    <= req_addr;
            h_wdata   <= req_wdata;
            h_wstrb   <= req_wstrb;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase

      if (exec) begin
        resp_err   <= (err_code != ERR_NONE);
        resp_rdata <= '0;
        case (region)
          RG_MEM: begin
            if (!acc_write) resp_rdata <= mem[acc_idx];
          end
          RG_TOHOST: begin
            if (acc_write) begin
              tohost       <= merge_bytes(tohost, acc_wdata, acc_wstrb);
              tohost_valid <= 1'b1;
            end else begin
              resp_rdata <= tohost;
            end
          end
          RG_CYCLE: begin
            if (!acc_write) resp_rdata <= cycle_cnt;
          end
          default: begin
            resp_rdata <= '0;
          end
        endcase
      end
    end
  end

endmodule
